// File: rtl/snake_row_renderer_pkg.sv
// Shared constants, colours and scan FSM encoding for the snake row renderer.
// The grid-line overlay is enabled with the SNAKE_RENDER_GRID_EN macro.
package snake_row_renderer_pkg;

    // Grid geometry: 16 px cells, 40 x 30 cells on a 640 x 480 screen
    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int CELL_SHIFT = 4;

    // Field widths
    localparam int COORD_W    = 10;  // pixel / segment coordinate width
    localparam int CELL_W     = 6;   // grid column / row index width
    localparam int LEN_W      = 7;   // snake_length width
    localparam int RGB_W      = 12;

    // Typed bounds so comparisons stay width-matched
    localparam logic [COORD_W-1:0] GRID_W_COORD = COORD_W'(GRID_W);
    localparam logic [CELL_W-1:0]  GRID_W_CELL  = CELL_W'(GRID_W);
    localparam logic [CELL_W-1:0]  COL_LAST     = CELL_W'(GRID_W - 1);
    localparam logic [CELL_W-1:0]  ROW_LAST     = CELL_W'(GRID_H - 1);

    // 4:4:4 colours
    localparam logic [RGB_W-1:0] COL_BLANK     = 12'h000;
    localparam logic [RGB_W-1:0] COL_BG        = 12'h111;
    localparam logic [RGB_W-1:0] COL_GRID      = 12'h222;
    localparam logic [RGB_W-1:0] COL_WALL      = 12'h888;
    localparam logic [RGB_W-1:0] COL_BODY      = 12'h080;
    localparam logic [RGB_W-1:0] COL_HEAD      = 12'h0F0;
    localparam logic [RGB_W-1:0] COL_APPLE     = 12'hF40;
    localparam logic [RGB_W-1:0] COL_DEAD_BODY = 12'h800;
    localparam logic [RGB_W-1:0] COL_DEAD_HEAD = 12'hF00;

    // Row scan FSM: START is the set-up cycle right after line_start
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_SCAN   = 2'd2,
        ST_COMMIT = 2'd3
    } scan_state_t;

endpackage

// File: rtl/snake_row_renderer_if.sv
// Bundle between the snake engine / VGA timing side (master) and the renderer (slave).
// Signalling: there is no valid/ready pair here. line_start is a one-cycle strobe
// that is always accepted (a strobe during a scan restarts it); every other master
// signal is a level sampled on clk; scan_busy, rgb and scan_state are level outputs.
interface snake_row_renderer_if #(
    parameter int SNAKE_MAX = 64
);
    import snake_row_renderer_pkg::*;

    logic                           line_start;
    logic [COORD_W-1:0]             line_y;
    logic                           video_on;
    logic [COORD_W-1:0]             pixel_x;
    logic [COORD_W*SNAKE_MAX-1:0]   snake_x;
    logic [COORD_W*SNAKE_MAX-1:0]   snake_y;
    logic [LEN_W-1:0]               snake_length;
    logic [COORD_W-1:0]             apple_x;
    logic [COORD_W-1:0]             apple_y;
    logic                           game_over;
    logic                           scan_busy;
    logic [RGB_W-1:0]               rgb;
    scan_state_t                    scan_state;   // debug view of the scan FSM

    modport master (
        output line_start, line_y, video_on, pixel_x,
        output snake_x, snake_y, snake_length, apple_x, apple_y, game_over,
        input  scan_busy, rgb, scan_state
    );

    modport slave (
        input  line_start, line_y, video_on, pixel_x,
        input  snake_x, snake_y, snake_length, apple_x, apple_y, game_over,
        output scan_busy, rgb, scan_state
    );

endinterface

// File: rtl/snake_row_renderer_scanner.sv
// Row scanner: walks the snake segment arrays one entry per clock during hblank,
// builds a GRID_W-bit occupancy row and publishes it as the display set on commit.
// With SNAKE_RENDER_GRID_EN defined the low line bits are also carried to the display set.
module snake_row_scanner
    import snake_row_renderer_pkg::*;
#(
    parameter int SNAKE_MAX = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         line_start,
    input  logic [COORD_W-1:0]           line_y,
    input  logic [COORD_W*SNAKE_MAX-1:0] snake_x,
    input  logic [COORD_W*SNAKE_MAX-1:0] snake_y,
    input  logic [LEN_W-1:0]             snake_length,
    input  logic [COORD_W-1:0]           apple_x,
    input  logic [COORD_W-1:0]           apple_y,
    output logic [GRID_W-1:0]            disp_bits,
    output logic                         disp_head_hit,
    output logic [CELL_W-1:0]            disp_head_col,
    output logic                         disp_apple_hit,
    output logic [CELL_W-1:0]            disp_apple_col,
    output logic [CELL_W-1:0]            disp_row,
`ifdef SNAKE_RENDER_GRID_EN
    output logic [CELL_SHIFT-1:0]        disp_line_lo,
`endif
    output logic                         scan_busy,
    output scan_state_t                  state
);

    localparam int IDX_W = (SNAKE_MAX > 1) ? $clog2(SNAKE_MAX) : 1;

    scan_state_t         state_q;
    scan_state_t         state_d;

    logic [CELL_W-1:0]   row_q;
    logic [LEN_W-1:0]    n_q;
    logic [IDX_W-1:0]    idx_q;
    logic [GRID_W-1:0]   build_q;
    logic                head_hit_q;
    logic [CELL_W-1:0]   head_col_q;
    logic                apple_hit_q;
    logic [CELL_W-1:0]   apple_col_q;
`ifdef SNAKE_RENDER_GRID_EN
    logic [CELL_SHIFT-1:0] line_lo_q;
`endif

    logic [LEN_W-1:0]    n_in;
    logic [COORD_W-1:0]  seg_x;
    logic [COORD_W-1:0]  seg_y;
    logic                seg_on_row;
    logic                last_seg;

    // Segment count clamped to the array depth; entries past it are never looked at
    assign n_in = (snake_length > LEN_W'(SNAKE_MAX)) ? LEN_W'(SNAKE_MAX) : snake_length;

    // Live view of the segment currently addressed by idx_q
    assign seg_x      = snake_x[idx_q*COORD_W +: COORD_W];
    assign seg_y      = snake_y[idx_q*COORD_W +: COORD_W];
    assign seg_on_row = (seg_y == COORD_W'(row_q)) && (seg_x < GRID_W_COORD);
    assign last_seg   = (LEN_W'(idx_q) == (n_q - LEN_W'(1)));

    assign scan_busy = (state_q != ST_IDLE);
    assign state     = state_q;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a new line_start always restarts the scan from the set-up cycle
    always_comb begin
        state_d = state_q;
        if (line_start) begin
            state_d = ST_START;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_IDLE;
                ST_START:  state_d = (n_q == '0) ? ST_COMMIT : ST_SCAN;
                ST_SCAN:   state_d = last_seg ? ST_COMMIT : ST_SCAN;
                ST_COMMIT: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Build-side datapath: latch line parameters, clear, accumulate segments, capture head/apple
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q       <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            build_q     <= '0;
            head_hit_q  <= 1'b0;
            head_col_q  <= '0;
            apple_hit_q <= 1'b0;
            apple_col_q <= '0;
`ifdef SNAKE_RENDER_GRID_EN
            line_lo_q   <= '0;
`endif
        end else if (line_start) begin
            row_q     <= line_y[COORD_W-1:CELL_SHIFT];
            n_q       <= n_in;
            idx_q     <= '0;
`ifdef SNAKE_RENDER_GRID_EN
            line_lo_q <= line_y[CELL_SHIFT-1:0];
`endif
        end else begin
            case (state_q)
                ST_START: begin
                    build_q     <= '0;
                    head_hit_q  <= 1'b0;
                    head_col_q  <= '0;
                    apple_hit_q <= (apple_y == COORD_W'(row_q)) && (apple_x < GRID_W_COORD);
                    apple_col_q <= apple_x[CELL_W-1:0];
                    idx_q       <= '0;
                end
                ST_SCAN: begin
                    if (seg_on_row) begin
                        build_q[seg_x[CELL_W-1:0]] <= 1'b1;
                    end
                    if (idx_q == '0) begin
                        head_hit_q <= seg_on_row;
                        head_col_q <= seg_x[CELL_W-1:0];
                    end
                    idx_q <= idx_q + IDX_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Display set: only replaced by a COMMIT that is not pre-empted by a new line_start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_bits      <= '0;
            disp_head_hit  <= 1'b0;
            disp_head_col  <= '0;
            disp_apple_hit <= 1'b0;
            disp_apple_col <= '0;
            disp_row       <= '0;
`ifdef SNAKE_RENDER_GRID_EN
            disp_line_lo   <= '0;
`endif
        end else if (!line_start && state_q == ST_COMMIT) begin
            disp_bits      <= build_q;
            disp_head_hit  <= head_hit_q;
            disp_head_col  <= head_col_q;
            disp_apple_hit <= apple_hit_q;
            disp_apple_col <= apple_col_q;
            disp_row       <= row_q;
`ifdef SNAKE_RENDER_GRID_EN
            disp_line_lo   <= line_lo_q;
`endif
        end
    end

endmodule

// File: rtl/snake_row_renderer.sv
// Snake row renderer top: row scanner plus the per-pixel colour mux and output register.
// SNAKE_RENDER_GRID_EN adds 12'h222 grid lines on non-wall, non-object cell edges.
module snake_row_renderer
    import snake_row_renderer_pkg::*;
#(
    parameter int SNAKE_MAX = 64
) (
    input  logic             clk,
    input  logic             reset,
    snake_row_renderer_if.slave bus
);

    logic [GRID_W-1:0]     disp_bits;
    logic                  disp_head_hit;
    logic [CELL_W-1:0]     disp_head_col;
    logic                  disp_apple_hit;
    logic [CELL_W-1:0]     disp_apple_col;
    logic [CELL_W-1:0]     disp_row;
    logic                  scan_busy;
    scan_state_t           scan_state;
`ifdef SNAKE_RENDER_GRID_EN
    logic [CELL_SHIFT-1:0] disp_line_lo;
`endif

    logic [CELL_W-1:0]     col;
    logic                  in_grid;
    logic                  head_px;
    logic                  body_px;
    logic                  apple_px;
    logic                  wall_px;
    logic [RGB_W-1:0]      rgb_d;
    logic [RGB_W-1:0]      rgb_q;

    snake_row_scanner #(
        .SNAKE_MAX (SNAKE_MAX)
    ) u_scanner (
        .clk            (clk),
        .reset          (reset),
        .line_start     (bus.line_start),
        .line_y         (bus.line_y),
        .snake_x        (bus.snake_x),
        .snake_y        (bus.snake_y),
        .snake_length   (bus.snake_length),
        .apple_x        (bus.apple_x),
        .apple_y        (bus.apple_y),
        .disp_bits      (disp_bits),
        .disp_head_hit  (disp_head_hit),
        .disp_head_col  (disp_head_col),
        .disp_apple_hit (disp_apple_hit),
        .disp_apple_col (disp_apple_col),
        .disp_row       (disp_row),
`ifdef SNAKE_RENDER_GRID_EN
        .disp_line_lo   (disp_line_lo),
`endif
        .scan_busy      (scan_busy),
        .state          (scan_state)
    );

    assign col      = bus.pixel_x[COORD_W-1:CELL_SHIFT];
    assign in_grid  = (col < GRID_W_CELL);
    assign head_px  = disp_head_hit && (col == disp_head_col);
    assign body_px  = in_grid && disp_bits[col];
    assign apple_px = disp_apple_hit && (col == disp_apple_col);
    assign wall_px  = (col == '0) || (col == COL_LAST) ||
                      (disp_row == '0) || (disp_row == ROW_LAST);

    // Colour priority: blank, head, body, apple, wall, then background (or grid lines)
    always_comb begin
        rgb_d = COL_BG;
        if (!bus.video_on || !in_grid) begin
            rgb_d = COL_BLANK;
        end else if (head_px) begin
            rgb_d = bus.game_over ? COL_DEAD_HEAD : COL_HEAD;
        end else if (body_px) begin
            rgb_d = bus.game_over ? COL_DEAD_BODY : COL_BODY;
        end else if (apple_px) begin
            rgb_d = COL_APPLE;
        end else if (wall_px) begin
            rgb_d = COL_WALL;
`ifdef SNAKE_RENDER_GRID_EN
        end else if ((bus.pixel_x[CELL_SHIFT-1:0] == '0) || (disp_line_lo == '0)) begin
            rgb_d = COL_GRID;
`endif
        end else begin
            rgb_d = COL_BG;
        end
    end

    // Registered colour output, one clock behind pixel_x / video_on
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign bus.rgb        = rgb_q;
    assign bus.scan_busy  = scan_busy;
    assign bus.scan_state = scan_state;

endmodule

// File: tb/tb_snake_row_renderer.sv
// Self-checking bench for snake_row_renderer: directed scenarios plus a randomised
// sweep checked against an independent per-pixel reference model.
module tb_snake_row_renderer;
    import snake_row_renderer_pkg::*;

    localparam int SMAX = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    snake_row_renderer_if #(.SNAKE_MAX(SMAX)) bus ();

    snake_row_renderer #(.SNAKE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- bench state ----------------
    int sx [SMAX];
    int sy [SMAX];
    int len;
    int ax;
    int ay;
    bit go;
    int cur_line;

    logic [RGB_W-1:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [RGB_W-1:0] ref_colour(input int line, input int x, input bit von);
        int row;
        int col;
        int n;
        bit head;
        bit body;
        bit apple;
        bit wall;
        row = line / 16;
        col = x / 16;
        if (!von || col >= GRID_W) return 12'h000;
        n = (len > SMAX) ? SMAX : len;
        head = (n > 0) && (sy[0] == row) && (sx[0] == col);
        body = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (sy[i] == row && sx[i] == col) body = 1'b1;
        end
        apple = (ay == row) && (ax == col);
        wall  = (col == 0) || (col == GRID_W - 1) || (row == 0) || (row == GRID_H - 1);
        if (head)  return go ? 12'hF00 : 12'h0F0;
        if (body)  return go ? 12'h800 : 12'h080;
        if (apple) return 12'hF40;
        if (wall)  return 12'h888;
`ifdef SNAKE_RENDER_GRID_EN
        if ((x % 16) == 0 || (line % 16) == 0) return 12'h222;
`endif
        return 12'h111;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_engine();
        for (int i = 0; i < SMAX; i++) begin
            bus.snake_x[i*COORD_W +: COORD_W] = COORD_W'(sx[i]);
            bus.snake_y[i*COORD_W +: COORD_W] = COORD_W'(sy[i]);
        end
        bus.snake_length = LEN_W'(len);
        bus.apple_x      = COORD_W'(ax);
        bus.apple_y      = COORD_W'(ay);
        bus.game_over    = go;
    endtask

    task automatic reset_snake();
        for (int i = 0; i < SMAX; i++) begin
            sx[i] = 0;
            sy[i] = 0;
        end
        for (int i = 0; i < 5; i++) begin
            sx[i] = 20;
            sy[i] = 15 + i;
        end
        len = 5;
        ax  = 10;
        ay  = 7;
        go  = 1'b0;
    endtask

    // One-cycle line_start strobe; returns just after the edge that samples it
    task automatic pulse_line(input int y);
        @(posedge clk);
        #1;
        bus.line_start = 1'b1;
        bus.line_y     = COORD_W'(y);
        @(posedge clk);
        #1;
        bus.line_start = 1'b0;
        cur_line = y;
    endtask

    // Count busy cycles until the scan commits, bounded
    task automatic wait_commit(input int exp_busy, input string tag);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (bus.scan_busy === 1'b1 && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        check_eq(tag, cnt, exp_busy);
        if (cnt >= 300) check_eq({tag, "_timeout"}, 1, 0);
    endtask

    task automatic render_line(input int y, input int exp_busy, input string tag);
        pulse_line(y);
        wait_commit(exp_busy, tag);
    endtask

    // Drive one pixel, push the expected colour, compare when the registered rgb appears
    task automatic pixel_exp(input int x, input bit von, input logic [RGB_W-1:0] exp, input string tag);
        logic [RGB_W-1:0] want;
        @(posedge clk);
        #1;
        bus.pixel_x  = COORD_W'(x);
        bus.video_on = von;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check_eq(tag, bus.rgb, want);
    endtask

    task automatic pixel_model(input int x, input bit von, input string tag);
        pixel_exp(x, von, ref_colour(cur_line, x, von), tag);
    endtask

    // ---------------- global watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.line_start = 1'b0;
        bus.line_y     = '0;
        bus.video_on   = 1'b0;
        bus.pixel_x    = '0;
        cur_line       = 0;
        reset_snake();
        load_engine();

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_rgb",   bus.rgb, 12'h000);
        check_eq("reset_busy",  bus.scan_busy, 1'b0);
        check_eq("reset_state", bus.scan_state, ST_IDLE);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_reset_rgb_blank", bus.rgb, 12'h000);
        // Cleared display set, latched row 0: every visible pixel is wall
        pixel_exp(320, 1'b1, 12'h888, "cleared_row_wall");

        // 1. head row
        render_line(240, 7, "t1_busy");
        pixel_exp(320, 1'b1, 12'h0F0, "t1_head_320");
        pixel_exp(327, 1'b1, 12'h0F0, "t1_head_327");
        pixel_exp(335, 1'b1, 12'h0F0, "t1_head_335");
        pixel_exp(336, 1'b1, 12'h111, "t1_bg_336");
        pixel_exp(304, 1'b1, 12'h111, "t1_bg_304");

        // 2. body row
        render_line(256, 7, "t2_busy");
        pixel_exp(320, 1'b1, 12'h080, "t2_body_320");
        pixel_exp(336, 1'b1, 12'h111, "t2_bg_336");

        // 3. apple row and wall column
        render_line(112, 7, "t3_busy");
        pixel_exp(160, 1'b1, 12'hF40, "t3_apple");
        pixel_exp(0,   1'b1, 12'h888, "t3_wall_left");
        pixel_exp(639, 1'b1, 12'h888, "t3_wall_right");
        pixel_exp(320, 1'b1, 12'h111, "t3_bg");

        // 4. game over colours
        go = 1'b1;
        load_engine();
        render_line(240, 7, "t4_busy_head");
        pixel_exp(320, 1'b1, 12'hF00, "t4_dead_head");
        render_line(256, 7, "t4_busy_body");
        pixel_exp(320, 1'b1, 12'h800, "t4_dead_body");
        go = 1'b0;
        load_engine();
        pixel_exp(320, 1'b1, 12'h080, "t4_live_body");

        // 5. restart mid-scan: display keeps row 16 until the new scan commits
        bus.pixel_x  = 10'd320;
        bus.video_on = 1'b1;
        pulse_line(240);
        @(negedge clk);
        check_eq("t5_busy_a", bus.scan_busy, 1'b1);
        @(negedge clk);
        check_eq("t5_busy_b", bus.scan_busy, 1'b1);
        check_eq("t5_disp_held", bus.rgb, 12'h080);
        pulse_line(0);
        wait_commit(7, "t5_restart_busy");
        pixel_exp(0,   1'b1, 12'h888, "t5_wall_0");
        pixel_exp(320, 1'b1, 12'h888, "t5_wall_320");
        pixel_exp(639, 1'b1, 12'h888, "t5_wall_639");

        // 6. empty snake, blanking, off-grid pixel
        len = 0;
        load_engine();
        render_line(240, 2, "t6_busy_empty");
        pixel_exp(320, 1'b1, 12'h111, "t6_no_snake");
        pixel_exp(320, 1'b0, 12'h000, "t6_video_off");
        pixel_exp(700, 1'b1, 12'h000, "t6_offgrid");

        // Length clamp: 100 requested, 64 scanned; all cells of row 5 occupied
        for (int i = 0; i < SMAX; i++) begin
            sx[i] = i % GRID_W;
            sy[i] = 5;
        end
        len = 100;
        load_engine();
        render_line(80, SMAX + 2, "clamp_busy");
        pixel_model(0,   1'b1, "clamp_head");
        pixel_model(160, 1'b1, "clamp_body_mid");
        pixel_model(630, 1'b1, "clamp_body_last");

        // Stale entries beyond length ignored; off-grid x (69) must not alias to col 5
        sx[1] = 69;
        len = 3;
        load_engine();
        render_line(80, 5, "stale_busy");
        pixel_model(0,  1'b1, "stale_head");
        pixel_model(32, 1'b1, "stale_body");
        pixel_model(48, 1'b1, "stale_ignored");
        pixel_model(80, 1'b1, "offgrid_seg_ignored");

        // Randomised sweep against the reference model
        for (int r = 0; r < 12; r++) begin
            reset_snake();
            len = $urandom_range(1, 10);
            for (int i = 0; i < SMAX; i++) begin
                sx[i] = $urandom_range(0, 45);
                sy[i] = $urandom_range(0, 31);
            end
            sy[0] = $urandom_range(0, 29);
            ax = $urandom_range(0, 42);
            ay = $urandom_range(0, 29);
            go = ($urandom_range(0, 3) == 0);
            load_engine();
            begin
                int line;
                line = sy[$urandom_range(0, len - 1)] * 16 + $urandom_range(0, 15);
                if (line > 479) line = $urandom_range(0, 479);
                render_line(line, len + 2, "rand_busy");
            end
            pixel_model(sx[0] * 16 + $urandom_range(0, 15), 1'b1, "rand_head_col");
            pixel_model(ax * 16, 1'b1, "rand_apple_col");
            for (int k = 0; k < 6; k++) begin
                pixel_model($urandom_range(0, 700), ($urandom_range(0, 7) != 0), "rand_px");
            end
        end

        if (exp_q.size() != 0) check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
